// File: rtl/simon_spi_pkg.sv
// Shared command codes, FSM state type and frame geometry for the SIMON SPI host.
package simon_spi_pkg;

  localparam logic [7:0] CMD_WRITE_KEY   = 8'h01;
  localparam logic [7:0] CMD_WRITE_BLOCK = 8'h02;
  localparam logic [7:0] CMD_ENCRYPT     = 8'h03;
  localparam logic [7:0] CMD_DECRYPT     = 8'h04;
  localparam logic [7:0] CMD_READ_STATUS = 8'h05;
  localparam logic [7:0] CMD_READ_RESULT = 8'h06;

  typedef enum logic [2:0] {
    IDLE, KEY, BLK, GO, POLL, RD, GAP, FIN
  } state_t;

  // Number of bytes (command included) in the frame sent from each state.
  function automatic logic [3:0] frame_len(input state_t st);
    logic [3:0] len;
    case (st)
      KEY:     len = 4'd9;
      BLK:     len = 4'd5;
      POLL:    len = 4'd2;
      RD:      len = 4'd5;
      default: len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/spi_master_byte.sv
// Mode-3 byte shifter: SCK idles high, MOSI moves on falling edges, MISO sampled on rising edges.
module spi_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  logic [7:0] div_reg;
  logic [3:0] edge_reg;
  logic [6:0] shift_reg;
  logic [7:0] rx_reg;
  logic       active_reg;
  logic       sck_reg;
  logic       mosi_reg;
  logic       div_wrap;

  assign div_wrap  = (div_reg == 8'(CLK_DIV - 1));
  // High in the last clk of a byte; a load in that cycle starts the next byte with no gap.
  assign byte_done = active_reg && div_wrap && (edge_reg == 4'd15);
  assign sck       = sck_reg;
  assign mosi      = mosi_reg;
  assign busy      = active_reg;
  assign rx_byte   = rx_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_reg    <= '0;
      edge_reg   <= '0;
      shift_reg  <= '0;
      rx_reg     <= '0;
      active_reg <= 1'b0;
      sck_reg    <= 1'b1;
      mosi_reg   <= 1'b0;
    end else if (load && (!active_reg || byte_done)) begin
      active_reg <= 1'b1;
      sck_reg    <= 1'b0;
      mosi_reg   <= tx_byte[7];
      shift_reg  <= tx_byte[6:0];
      div_reg    <= '0;
      edge_reg   <= '0;
    end else if (active_reg) begin
      if (div_wrap) begin
        div_reg <= '0;
        if (edge_reg == 4'd15) begin
          active_reg <= 1'b0;
          mosi_reg   <= 1'b0;
        end else begin
          edge_reg <= edge_reg + 4'd1;
          if (!edge_reg[0]) begin
            sck_reg <= 1'b1;
            rx_reg  <= {rx_reg[6:0], miso};
          end else begin
            sck_reg   <= 1'b0;
            mosi_reg  <= shift_reg[6];
            shift_reg <= {shift_reg[5:0], 1'b0};
          end
        end
      end else begin
        div_reg <= div_reg + 8'd1;
      end
    end
  end

endmodule

// File: rtl/simon_spi_host.sv
// SPI host that drives a SIMON cipher slave: key/block upload, start, status polling, result read.
module simon_spi_host #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_CYC  = 16,
  parameter int MAX_POLL = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic        load_key,
  input  logic [63:0] key,
  input  logic [31:0] block,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  input  logic        spi_miso
);

  import simon_spi_pkg::*;

  state_t      state_reg;
  state_t      after_gap_reg;
  logic        cs_n_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        timeout_reg;
  logic [31:0] result_reg;
  logic [23:0] rd_buf_reg;
  logic [63:0] key_reg;
  logic [31:0] block_reg;
  logic        decrypt_reg;
  logic [3:0]  byte_idx_reg;
  logic [15:0] cnt_reg;
  logic [15:0] poll_cnt_reg;
  logic        setup_reg;

  logic        in_frame;
  logic        last_byte;
  logic        setup_end;
  logic        byte_load;
  logic [3:0]  load_idx;
  logic [7:0]  tx_byte;
  logic        byte_busy;
  logic        byte_done;
  logic [7:0]  rx_byte;

  assign result   = result_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign timeout  = timeout_reg;
  assign spi_cs_n = cs_n_reg;

  assign in_frame  = state_reg inside {KEY, BLK, GO, POLL, RD};
  assign last_byte = (byte_idx_reg == frame_len(state_reg) - 4'd1);
  assign setup_end = setup_reg && (cnt_reg == 16'(CLK_DIV - 1));
  assign byte_load = in_frame && ((setup_end && !byte_busy) || (byte_done && !last_byte));
  assign load_idx  = setup_reg ? 4'd0 : byte_idx_reg + 4'd1;

  // Payload bytes go out least-significant byte first.
  always_comb begin
    tx_byte = 8'h00;
    if (load_idx == 4'd0) begin
      case (state_reg)
        KEY:     tx_byte = CMD_WRITE_KEY;
        BLK:     tx_byte = CMD_WRITE_BLOCK;
        GO:      tx_byte = decrypt_reg ? CMD_DECRYPT : CMD_ENCRYPT;
        POLL:    tx_byte = CMD_READ_STATUS;
        RD:      tx_byte = CMD_READ_RESULT;
        default: tx_byte = 8'h00;
      endcase
    end else if (state_reg == KEY) begin
      tx_byte = key_reg[{load_idx[2:0] - 3'd1, 3'b000} +: 8];
    end else if (state_reg == BLK) begin
      tx_byte = block_reg[{load_idx[1:0] - 2'd1, 3'b000} +: 8];
    end
  end

  spi_master_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (byte_load),
    .tx_byte   (tx_byte),
    .miso      (spi_miso),
    .sck       (spi_sck),
    .mosi      (spi_mosi),
    .busy      (byte_busy),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      after_gap_reg <= IDLE;
      cs_n_reg      <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      result_reg    <= '0;
      rd_buf_reg    <= '0;
      key_reg       <= '0;
      block_reg     <= '0;
      decrypt_reg   <= 1'b0;
      byte_idx_reg  <= '0;
      cnt_reg       <= '0;
      poll_cnt_reg  <= '0;
      setup_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            key_reg      <= key;
            block_reg    <= block;
            decrypt_reg  <= decrypt;
            timeout_reg  <= 1'b0;
            busy_reg     <= 1'b1;
            cs_n_reg     <= 1'b0;
            setup_reg    <= 1'b1;
            cnt_reg      <= '0;
            byte_idx_reg <= '0;
            poll_cnt_reg <= '0;
            state_reg    <= load_key ? KEY : BLK;
          end
        end
        KEY, BLK, GO, POLL, RD: begin
          if (setup_reg) begin
            if (setup_end) setup_reg <= 1'b0;
            else           cnt_reg   <= cnt_reg + 16'd1;
          end else if (byte_done) begin
            if (!last_byte) begin
              byte_idx_reg <= byte_idx_reg + 4'd1;
              if (state_reg == RD && byte_idx_reg != 4'd0)
                rd_buf_reg[{byte_idx_reg[1:0] - 2'd1, 3'b000} +: 8] <= rx_byte;
            end else begin
              cs_n_reg <= 1'b1;
              cnt_reg  <= '0;
              case (state_reg)
                KEY: begin
                  state_reg     <= GAP;
                  after_gap_reg <= BLK;
                end
                BLK: begin
                  state_reg     <= GAP;
                  after_gap_reg <= GO;
                end
                GO: begin
                  state_reg     <= GAP;
                  after_gap_reg <= POLL;
                end
                POLL: begin
                  poll_cnt_reg <= poll_cnt_reg + 16'd1;
                  if (rx_byte[0]) begin
                    state_reg     <= GAP;
                    after_gap_reg <= RD;
                  end else if (poll_cnt_reg == 16'(MAX_POLL - 1)) begin
                    state_reg   <= FIN;
                    timeout_reg <= 1'b1;
                    done_reg    <= 1'b1;
                    busy_reg    <= 1'b0;
                  end else begin
                    state_reg     <= GAP;
                    after_gap_reg <= POLL;
                  end
                end
                default: begin
                  result_reg <= {rx_byte, rd_buf_reg};
                  state_reg  <= FIN;
                  done_reg   <= 1'b1;
                  busy_reg   <= 1'b0;
                end
              endcase
            end
          end
        end
        GAP: begin
          if (cnt_reg == 16'(GAP_CYC - 1)) begin
            state_reg    <= after_gap_reg;
            cs_n_reg     <= 1'b0;
            setup_reg    <= 1'b1;
            cnt_reg      <= '0;
            byte_idx_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        FIN:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_spi_host.sv
// Directed bench: Mode-3 SPI slave with the published SIMON32/64 vector, bus timing monitor.
module tb_simon_spi_host;

  localparam int CLK_DIV  = 4;
  localparam int GAP_CYC  = 16;
  localparam int MAX_POLL = 3;
  localparam logic [63:0] KEY_V = 64'h1918111009080100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic        load_key = 1'b0;
  logic [63:0] key = '0;
  logic [31:0] block = '0;
  logic [31:0] result;
  logic        busy, done, timeout;
  logic        spi_sck, spi_mosi, spi_cs_n;
  logic        spi_miso = 1'b0;

  int tests = 0;
  int fails = 0;

  simon_spi_host #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .MAX_POLL(MAX_POLL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .load_key(load_key),
    .key(key), .block(block), .result(result), .busy(busy), .done(done), .timeout(timeout),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  // Slave and bus monitor state
  logic [7:0]  s_cmd = 8'h00, s_rx = 8'h00, s_tx = 8'h00;
  logic [63:0] s_key = '0;
  logic [31:0] s_blk = '0, s_res = '0;
  logic        s_stuck = 1'b0;
  int          s_bit = 0, s_byte = 0, s_polls = 0;
  logic [63:0] flog = '0;
  int nframes = 0, rises = 0, done_cyc = 0;
  int v_period = 0, v_stable = 0, v_gap = 0, v_setup = 0, v_hold = 0, v_idle = 0;
  logic p_sck = 1'b1, p_cs = 1'b1, p_mosi = 1'b0;
  int cyc = 0, t_rise = -1, t_csf = 0, t_csr = 0;
  bit first_fall = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (done) done_cyc++;
    if (spi_cs_n && spi_mosi) v_idle++;
    if (p_cs && !spi_cs_n) begin
      if (cyc - t_csr < GAP_CYC) v_gap++;
      t_csf = cyc; t_rise = -1; first_fall = 1'b1;
      s_bit = 0; s_byte = 0; s_cmd = 8'h00;
    end
    if (!p_cs && spi_cs_n) begin
      t_csr = cyc;
      if (rst_n && t_rise >= 0 && cyc - t_rise != CLK_DIV) v_hold++;
      spi_miso = 1'b0;
    end
    if (!spi_cs_n && p_sck && !spi_sck) begin
      if (first_fall && cyc - t_csf != CLK_DIV) v_setup++;
      first_fall = 1'b0;
      if (s_bit == 0) begin
        s_tx = 8'h00;
        if (s_cmd == 8'h05 && s_byte == 1) begin
          s_tx = {7'd0, !s_stuck && s_polls == 0};
          if (s_polls > 0) s_polls--;
        end else if (s_cmd == 8'h06 && s_byte >= 1 && s_byte <= 4) begin
          s_tx = s_res[8*(s_byte-1) +: 8];
        end
      end
      spi_miso = s_tx[7 - s_bit];
    end
    if (!spi_cs_n && !p_sck && spi_sck) begin
      rises++;
      if (t_rise >= 0 && cyc - t_rise != 2*CLK_DIV) v_period++;
      if (spi_mosi !== p_mosi) v_stable++;
      t_rise = cyc;
      s_rx = {s_rx[6:0], spi_mosi};
      s_bit++;
      if (s_bit == 8) begin
        if (s_byte == 0) begin
          s_cmd = s_rx;
          flog = {flog[55:0], s_rx};
          nframes++;
          if (s_rx == 8'h03 || s_rx == 8'h04) begin
            s_polls = 1;
            if (s_rx == 8'h03 && s_key == KEY_V && s_blk == 32'h65656877)      s_res = 32'hC69BE9BB;
            else if (s_rx == 8'h04 && s_key == KEY_V && s_blk == 32'hC69BE9BB) s_res = 32'h65656877;
            else                                                               s_res = 32'hBAD0BAD0;
          end
        end else if (s_cmd == 8'h01 && s_byte <= 8) begin
          s_key[8*(s_byte-1) +: 8] = s_rx;
        end else if (s_cmd == 8'h02 && s_byte <= 4) begin
          s_blk[8*(s_byte-1) +: 8] = s_rx;
        end
        s_byte++;
        s_bit = 0;
      end
    end
    p_sck = spi_sck; p_cs = spi_cs_n; p_mosi = spi_mosi;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    @(negedge clk);
    #1;
    flog = '0; nframes = 0; rises = 0; done_cyc = 0;
    v_period = 0; v_stable = 0; v_gap = 0; v_setup = 0; v_hold = 0; v_idle = 0;
  endtask

  // Inputs are scrambled right after the pulse so only the captured values can be used.
  task automatic pulse_start(input logic dec, input logic lk, input logic [31:0] blk);
    @(negedge clk);
    decrypt = dec; load_key = lk; key = KEY_V; block = blk; start = 1'b1;
    @(negedge clk);
    start = 1'b0; decrypt = ~dec; load_key = ~lk; key = '0; block = 32'hFFFF0000;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(done), 64'(1));
  endtask

  function automatic int bus_viol();
    return v_period + v_stable + v_gap + v_setup + v_hold + v_idle;
  endfunction

  initial begin
    int n;
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_cs_n", 64'(spi_cs_n), 64'(1));
    check("rst_sck", 64'(spi_sck), 64'(1));
    check("rst_mosi", 64'(spi_mosi), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Encrypt with key load; a second start mid-operation must be ignored
    clear_stats();
    pulse_start(1'b0, 1'b1, 32'h65656877);
    check("enc_busy", 64'(busy), 64'(1));
    repeat (100) @(negedge clk);
    start = 1'b1; decrypt = 1'b1; load_key = 1'b0; block = 32'h0;
    @(negedge clk);
    start = 1'b0;
    wait_done("enc_done", 6000);
    check("enc_result", 64'(result), 64'(32'hC69BE9BB));
    check("enc_timeout", 64'(timeout), 64'(0));
    check("enc_busy_at_done", 64'(busy), 64'(0));
    repeat (400) @(negedge clk);
    check("enc_done_pulses", 64'(done_cyc), 64'(1));
    check("enc_frames", flog, 64'h0000_0102_0305_0506);
    check("enc_nframes", 64'(nframes), 64'(6));
    check("enc_sck_rises", 64'(rises), 64'(192));
    check("enc_bus_viol", 64'(bus_viol()), 64'(0));

    // Decrypt without key load: no KEY frame, slave keeps the earlier key
    clear_stats();
    pulse_start(1'b1, 1'b0, 32'hC69BE9BB);
    wait_done("dec_done", 6000);
    check("dec_result", 64'(result), 64'(32'h65656877));
    check("dec_timeout", 64'(timeout), 64'(0));
    repeat (30) @(negedge clk);
    check("dec_done_pulses", 64'(done_cyc), 64'(1));
    check("dec_frames", flog, 64'h0000_0002_0405_0506);
    check("dec_sck_rises", 64'(rises), 64'(120));
    check("dec_bus_viol", 64'(bus_viol()), 64'(0));

    // Slave never ready: MAX_POLL status frames then timeout, result kept
    s_stuck = 1'b1;
    clear_stats();
    pulse_start(1'b0, 1'b0, 32'h65656877);
    wait_done("tmo_done", 6000);
    check("tmo_timeout", 64'(timeout), 64'(1));
    check("tmo_result_kept", 64'(result), 64'(32'h65656877));
    check("tmo_busy", 64'(busy), 64'(0));
    repeat (30) @(negedge clk);
    check("tmo_done_pulses", 64'(done_cyc), 64'(1));
    check("tmo_frames", flog, 64'h0000_0002_0305_0505);
    check("tmo_sck_rises", 64'(rises), 64'(96));
    check("tmo_bus_viol", 64'(bus_viol()), 64'(0));
    s_stuck = 1'b0;

    // Reset during the third KEY byte aborts at once
    clear_stats();
    pulse_start(1'b0, 1'b1, 32'h65656877);
    check("abort_timeout_clr", 64'(timeout), 64'(0));
    n = 0;
    while (!(s_cmd == 8'h01 && s_byte == 2 && s_bit == 3) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", 64'(n < 2000), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cs_n", 64'(spi_cs_n), 64'(1));
    check("abort_sck", 64'(spi_sck), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // A fresh operation after the abort runs normally
    clear_stats();
    pulse_start(1'b0, 1'b1, 32'h65656877);
    wait_done("post_done", 6000);
    check("post_result", 64'(result), 64'(32'hC69BE9BB));
    check("post_timeout", 64'(timeout), 64'(0));
    repeat (30) @(negedge clk);
    check("post_frames", flog, 64'h0000_0102_0305_0506);
    check("post_bus_viol", 64'(bus_viol()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
